// File: rtl/tmr_scrub_ctrl_pkg.sv
// Shared types and defaults for the TMR scrub controller.
package tmr_ctrl_pkg;

  // Scrub engine states: waiting for the next sweep, testing one register,
  // and the one-cycle settle slot after a refresh.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FIX   = 2'd2
  } scrub_state_t;

  localparam int SCRUB_PERIOD_DEFAULT = 1024;
  localparam int CNT_W_DEFAULT        = 16;

endpackage

// File: rtl/tmr_scrub_timer.sv
// Reloadable down-counter that paces the idle gap between scrub sweeps.
module tmr_scrub_timer #(
  parameter int TW     = 10,
  parameter int RELOAD = 1023
) (
  input  logic clk,
  input  logic resn,
  input  logic en,
  input  logic reload,
  output logic zero
);

  localparam logic [TW-1:0] RELOAD_VAL = TW'(RELOAD);

  logic [TW-1:0] count_r;

  // Reload has priority over counting so the terminal cycle restarts the gap.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      count_r <= RELOAD_VAL;
    end else if (reload) begin
      count_r <= RELOAD_VAL;
    end else if (en) begin
      count_r <= count_r - TW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {TW{1'b0}});

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// Scrub scheduler and write arbiter for a bank of triplicated registers.
// Host writes always win; the scrub engine refreshes registers whose voter
// reports a mismatch and counts the corrected upsets.
module tmr_scrub_ctrl
  import tmr_ctrl_pkg::*;
#(
  parameter int NREGS        = 8,
  parameter int WIDTH        = 8,
  parameter int SCRUB_PERIOD = SCRUB_PERIOD_DEFAULT,
  parameter int CNT_W        = CNT_W_DEFAULT,
  localparam int AW          = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             resn,
  input  logic             enable,
  input  logic             host_valid,
  output logic             host_ready,
  input  logic [AW-1:0]    host_addr,
  input  logic [WIDTH-1:0] host_data,
  input  logic [NREGS-1:0] reg_err,
  output logic [NREGS-1:0] reg_write,
  output logic [WIDTH-1:0] write_value,
  output logic [NREGS-1:0] reg_refresh,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clear,
  output logic             addr_err,
  output logic             sweep_done,
  output logic             busy
);

  localparam int TW = $clog2(SCRUB_PERIOD + 1);
  localparam logic [AW:0]      NREGS_L  = (AW+1)'(NREGS);
  localparam logic [AW-1:0]    LAST_IDX = AW'(NREGS - 1);
  localparam logic [NREGS-1:0] ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};

  scrub_state_t     state_r;
  logic [AW-1:0]    idx_r;
  logic             host_ready_r;
  logic [NREGS-1:0] reg_write_r;
  logic [WIDTH-1:0] write_value_r;
  logic [NREGS-1:0] reg_refresh_r;
  logic [CNT_W-1:0] err_count_r;
  logic             addr_err_r;
  logic             sweep_done_r;
  logic             busy_r;

  logic host_acc_s;
  logic addr_ok_s;
  logic err_hit_s;
  logic collide_s;
  logic refresh_go_s;
  logic timer_en_s;
  logic timer_reload_s;
  logic timer_zero_s;

  // Request decode, collision detection and timer control.
  always_comb begin
    host_acc_s     = host_valid & host_ready_r;
    addr_ok_s      = ({1'b0, host_addr} < NREGS_L);
    err_hit_s      = reg_err[idx_r];
    collide_s      = host_acc_s & (host_addr == idx_r);
    refresh_go_s   = (state_r == CHECK) & enable & err_hit_s & ~collide_s;
    timer_en_s     = (state_r == IDLE) & enable;
    timer_reload_s = ~timer_en_s | timer_zero_s;
  end

  tmr_scrub_timer #(
    .TW     (TW),
    .RELOAD (SCRUB_PERIOD - 1)
  ) u_timer (
    .clk    (clk),
    .resn   (resn),
    .en     (timer_en_s),
    .reload (timer_reload_s),
    .zero   (timer_zero_s)
  );

  // Host write path: one-cycle strobe, or an address-error pulse when out of range.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      host_ready_r  <= 1'b0;
      reg_write_r   <= {NREGS{1'b0}};
      write_value_r <= {WIDTH{1'b0}};
      addr_err_r    <= 1'b0;
    end else begin
      host_ready_r <= 1'b1;
      reg_write_r  <= {NREGS{1'b0}};
      addr_err_r   <= 1'b0;
      if (host_acc_s) begin
        if (addr_ok_s) begin
          reg_write_r   <= ONE_HOT0 << host_addr;
          write_value_r <= host_data;
        end else begin
          addr_err_r <= 1'b1;
        end
      end else begin
        write_value_r <= write_value_r;
      end
    end
  end

  // Scrub sequencer: walks the bank, issues refreshes and pulses sweep completion.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_r       <= IDLE;
      idx_r         <= {AW{1'b0}};
      reg_refresh_r <= {NREGS{1'b0}};
      sweep_done_r  <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      reg_refresh_r <= {NREGS{1'b0}};
      sweep_done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (timer_en_s && timer_zero_s) begin
            state_r <= CHECK;
            idx_r   <= {AW{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        CHECK: begin
          if (!enable) begin
            state_r <= IDLE;
            idx_r   <= {AW{1'b0}};
            busy_r  <= 1'b0;
          end else if (err_hit_s) begin
            // A colliding host write already reloads all copies, so no refresh.
            state_r <= FIX;
            if (!collide_s) begin
              reg_refresh_r <= ONE_HOT0 << idx_r;
            end else begin
              reg_refresh_r <= {NREGS{1'b0}};
            end
          end else if (idx_r == LAST_IDX) begin
            state_r      <= IDLE;
            idx_r        <= {AW{1'b0}};
            sweep_done_r <= 1'b1;
            busy_r       <= 1'b0;
          end else begin
            idx_r <= idx_r + AW'(1);
          end
        end
        FIX: begin
          if (!enable) begin
            state_r <= IDLE;
            idx_r   <= {AW{1'b0}};
            busy_r  <= 1'b0;
          end else if (idx_r == LAST_IDX) begin
            state_r      <= IDLE;
            idx_r        <= {AW{1'b0}};
            sweep_done_r <= 1'b1;
            busy_r       <= 1'b0;
          end else begin
            state_r <= CHECK;
            idx_r   <= idx_r + AW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= {AW{1'b0}};
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Corrected-upset counter: saturating, with clear taking precedence.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      err_count_r <= {CNT_W{1'b0}};
    end else if (err_clear) begin
      err_count_r <= {CNT_W{1'b0}};
    end else if (refresh_go_s && (err_count_r != {CNT_W{1'b1}})) begin
      err_count_r <= err_count_r + CNT_W'(1);
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign host_ready  = host_ready_r;
  assign reg_write   = reg_write_r;
  assign write_value = write_value_r;
  assign reg_refresh = reg_refresh_r;
  assign err_count   = err_count_r;
  assign addr_err    = addr_err_r;
  assign sweep_done  = sweep_done_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Directed self-checking bench for tmr_scrub_ctrl.
// dut: NREGS=8, SCRUB_PERIOD=4, CNT_W=2. dut2: NREGS=6 so that out-of-range
// addresses are representable on the 3-bit host_addr port.
module tb_tmr_scrub_ctrl;

  logic       clk = 1'b0;
  logic       resn;
  logic       enable, host_valid, host_ready, err_clear, addr_err, sweep_done, busy;
  logic [2:0] host_addr;
  logic [7:0] host_data, reg_err, reg_write, write_value, reg_refresh;
  logic [1:0] err_count;

  logic       en2, h2_valid, h2_ready, clr2, aerr2, done2, busy2;
  logic [2:0] h2_addr;
  logic [7:0] h2_data, wv2;
  logic [5:0] err2, wr2, ref2;
  logic [3:0] cnt2;

  int tests_run = 0;
  int tests_failed = 0;

  int         obs_done_first, obs_done_cnt, obs_busy_cnt, obs_ref_cnt, obs_ref_pos;
  logic [7:0] obs_ref_val, obs_wr, obs_wd;

  tmr_scrub_ctrl #(.NREGS(8), .WIDTH(8), .SCRUB_PERIOD(4), .CNT_W(2)) dut (
    .clk(clk), .resn(resn), .enable(enable), .host_valid(host_valid),
    .host_ready(host_ready), .host_addr(host_addr), .host_data(host_data),
    .reg_err(reg_err), .reg_write(reg_write), .write_value(write_value),
    .reg_refresh(reg_refresh), .err_count(err_count), .err_clear(err_clear),
    .addr_err(addr_err), .sweep_done(sweep_done), .busy(busy)
  );

  tmr_scrub_ctrl #(.NREGS(6), .WIDTH(8), .SCRUB_PERIOD(4), .CNT_W(4)) dut2 (
    .clk(clk), .resn(resn), .enable(en2), .host_valid(h2_valid),
    .host_ready(h2_ready), .host_addr(h2_addr), .host_data(h2_data),
    .reg_err(err2), .reg_write(wr2), .write_value(wv2),
    .reg_refresh(ref2), .err_count(cnt2), .err_clear(clr2),
    .addr_err(aerr2), .sweep_done(done2), .busy(busy2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Runs enable=1 for n cycles from IDLE, recording outputs at each negedge.
  // Optionally drives one host write at cycle host_at and err_clear at clr_at.
  task automatic run_window(input int n, input int host_at, input logic [2:0] ha,
                            input logic [7:0] hd, input int clr_at);
    obs_done_first = 0; obs_done_cnt = 0; obs_busy_cnt = 0;
    obs_ref_cnt = 0; obs_ref_pos = 0; obs_ref_val = 8'h00;
    obs_wr = 8'h00; obs_wd = 8'h00;
    host_addr = ha; host_data = hd;
    @(negedge clk);
    enable = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (sweep_done) begin
        obs_done_cnt++;
        if (obs_done_first == 0) obs_done_first = i;
      end
      if (busy) obs_busy_cnt++;
      if (reg_refresh != 8'h00) begin
        obs_ref_cnt++; obs_ref_pos = i; obs_ref_val = reg_refresh;
      end
      if (host_at > 0 && i == host_at + 1) begin
        obs_wr = reg_write; obs_wd = write_value;
      end
      host_valid = (i == host_at);
      err_clear  = (i == clr_at);
    end
    enable = 1'b0; host_valid = 1'b0; err_clear = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests_run++; if ({host_ready, reg_write, write_value, reg_refresh} !== 25'd0) begin tests_failed++; $display("FAIL reset_strobes: got %0h expected 0", {host_ready, reg_write, write_value, reg_refresh}); end
    tests_run++; if ({err_count, addr_err, sweep_done, busy} !== 5'd0) begin tests_failed++; $display("FAIL reset_status: got %0h expected 0", {err_count, addr_err, sweep_done, busy}); end
    @(negedge clk); resn = 1'b1;
    @(negedge clk);
    tests_run++; if (host_ready !== 1'b1) begin tests_failed++; $display("FAIL host_ready: got %0b expected 1", host_ready); end
  endtask

  task automatic test_host_write();
    int refs, bz;
    host_valid = 1'b1; host_addr = 3'd3; host_data = 8'hA5;
    @(negedge clk);
    tests_run++; if (reg_write !== 8'h08) begin tests_failed++; $display("FAIL hw_strobe: got %0h expected 08", reg_write); end
    tests_run++; if (write_value !== 8'hA5) begin tests_failed++; $display("FAIL hw_value: got %0h expected a5", write_value); end
    host_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (reg_write !== 8'h00) begin tests_failed++; $display("FAIL hw_single: got %0h expected 00", reg_write); end
    reg_err = 8'hFF; refs = 0; bz = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (reg_refresh != 8'h00) refs++;
      if (busy) bz++;
    end
    reg_err = 8'h00;
    tests_run++; if (refs !== 0 || bz !== 0) begin tests_failed++; $display("FAIL disabled_scrub: got refresh=%0d busy=%0d expected 0 0", refs, bz); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ba [3];
    logic [7:0] bd [3];
    logic [7:0] exp_wr;
    ba = '{3'd0, 3'd1, 3'd7};
    bd = '{8'h11, 8'h22, 8'h33};
    host_valid = 1'b1; host_addr = ba[0]; host_data = bd[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_wr = 8'h01 << ba[i];
      tests_run++; if (reg_write !== exp_wr || write_value !== bd[i]) begin tests_failed++; $display("FAIL b2b_%0d: got %0h/%0h expected %0h/%0h", i, reg_write, write_value, exp_wr, bd[i]); end
      if (i < 2) begin host_addr = ba[i+1]; host_data = bd[i+1]; end
      else host_valid = 1'b0;
    end
  endtask

  task automatic test_addr_err();
    h2_valid = 1'b1; h2_addr = 3'd7; h2_data = 8'h5A;
    @(negedge clk);
    tests_run++; if (aerr2 !== 1'b1 || wr2 !== 6'd0) begin tests_failed++; $display("FAIL addr7: got aerr=%0b wr=%0h expected 1 0", aerr2, wr2); end
    h2_addr = 3'd6;
    @(negedge clk);
    tests_run++; if (aerr2 !== 1'b1 || wr2 !== 6'd0) begin tests_failed++; $display("FAIL addr6: got aerr=%0b wr=%0h expected 1 0", aerr2, wr2); end
    h2_addr = 3'd5; h2_data = 8'hC3;
    @(negedge clk);
    tests_run++; if (aerr2 !== 1'b0 || wr2 !== 6'b100000 || wv2 !== 8'hC3) begin tests_failed++; $display("FAIL addr5: got aerr=%0b wr=%0h wv=%0h expected 0 20 c3", aerr2, wr2, wv2); end
    h2_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (aerr2 !== 1'b0 || wr2 !== 6'd0) begin tests_failed++; $display("FAIL addr_idle: got aerr=%0b wr=%0h expected 0 0", aerr2, wr2); end
  endtask

  task automatic test_sweep_clean();
    reg_err = 8'h00;
    run_window(24, 0, 3'd0, 8'h00, 0);
    tests_run++; if (obs_done_first !== 12 || obs_done_cnt !== 2) begin tests_failed++; $display("FAIL clean_done: got first=%0d cnt=%0d expected 12 2", obs_done_first, obs_done_cnt); end
    tests_run++; if (obs_busy_cnt !== 16) begin tests_failed++; $display("FAIL clean_busy: got %0d expected 16", obs_busy_cnt); end
    tests_run++; if (obs_ref_cnt !== 0 || err_count !== 2'd0) begin tests_failed++; $display("FAIL clean_err: got ref=%0d cnt=%0d expected 0 0", obs_ref_cnt, err_count); end
  endtask

  task automatic test_refresh();
    reg_err = 8'h20;
    run_window(13, 0, 3'd0, 8'h00, 0);
    reg_err = 8'h00;
    tests_run++; if (obs_ref_cnt !== 1 || obs_ref_val !== 8'h20 || obs_ref_pos !== 10) begin tests_failed++; $display("FAIL refresh: got n=%0d val=%0h pos=%0d expected 1 20 10", obs_ref_cnt, obs_ref_val, obs_ref_pos); end
    tests_run++; if (err_count !== 2'd1) begin tests_failed++; $display("FAIL refresh_cnt: got %0d expected 1", err_count); end
    tests_run++; if (obs_busy_cnt !== 9 || obs_done_first !== 13) begin tests_failed++; $display("FAIL refresh_len: got busy=%0d done=%0d expected 9 13", obs_busy_cnt, obs_done_first); end
  endtask

  task automatic test_collision();
    reg_err = 8'h20;
    run_window(13, 9, 3'd5, 8'h3C, 0);
    reg_err = 8'h00;
    tests_run++; if (obs_wr !== 8'h20 || obs_wd !== 8'h3C) begin tests_failed++; $display("FAIL coll_write: got %0h/%0h expected 20/3c", obs_wr, obs_wd); end
    tests_run++; if (obs_ref_cnt !== 0 || err_count !== 2'd1) begin tests_failed++; $display("FAIL coll_refresh: got ref=%0d cnt=%0d expected 0 1", obs_ref_cnt, err_count); end
    tests_run++; if (obs_busy_cnt !== 9 || obs_done_first !== 13) begin tests_failed++; $display("FAIL coll_len: got busy=%0d done=%0d expected 9 13", obs_busy_cnt, obs_done_first); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [4];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3};
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    tests_run++; if (err_count !== 2'd0) begin tests_failed++; $display("FAIL clear: got %0d expected 0", err_count); end
    reg_err = 8'h20;
    for (int k = 0; k < 4; k++) begin
      run_window(13, 0, 3'd0, 8'h00, 0);
      tests_run++; if (err_count !== exp_cnt[k]) begin tests_failed++; $display("FAIL sat_%0d: got %0d expected %0d", k, err_count, exp_cnt[k]); end
    end
    run_window(13, 0, 3'd0, 8'h00, 9);
    reg_err = 8'h00;
    tests_run++; if (err_count !== 2'd0 || obs_ref_cnt !== 1) begin tests_failed++; $display("FAIL clear_wins: got cnt=%0d ref=%0d expected 0 1", err_count, obs_ref_cnt); end
  endtask

  task automatic test_reset_mid();
    reg_err = 8'h20;
    @(negedge clk);
    enable = 1'b1;
    for (int i = 1; i <= 10; i++) @(negedge clk);
    tests_run++; if (reg_refresh !== 8'h20 || err_count !== 2'd1) begin tests_failed++; $display("FAIL pre_reset: got ref=%0h cnt=%0d expected 20 1", reg_refresh, err_count); end
    resn = 1'b0;
    #1;
    tests_run++; if (reg_refresh !== 8'h00 || busy !== 1'b0 || err_count !== 2'd0 || host_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_reset: got ref=%0h busy=%0b cnt=%0d rdy=%0b expected 0 0 0 0", reg_refresh, busy, err_count, host_ready); end
    enable = 1'b0; reg_err = 8'h00;
    @(negedge clk); resn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abort();
    reg_err = 8'h00;
    @(negedge clk);
    enable = 1'b1;
    for (int i = 1; i <= 8; i++) @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL abort_pre: got busy=%0b expected 1", busy); end
    enable = 1'b0;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0 || sweep_done !== 1'b0) begin tests_failed++; $display("FAIL abort: got busy=%0b done=%0b expected 0 0", busy, sweep_done); end
    reg_err = 8'h01;
    run_window(13, 0, 3'd0, 8'h00, 0);
    reg_err = 8'h00;
    tests_run++; if (obs_ref_val !== 8'h01 || obs_ref_pos !== 5 || obs_done_first !== 13) begin tests_failed++; $display("FAIL restart: got val=%0h pos=%0d done=%0d expected 01 5 13", obs_ref_val, obs_ref_pos, obs_done_first); end
    tests_run++; if (err_count !== 2'd1) begin tests_failed++; $display("FAIL restart_cnt: got %0d expected 1", err_count); end
  endtask

  initial begin
    resn = 1'b0; enable = 1'b0; host_valid = 1'b0; host_addr = 3'd0; host_data = 8'h00;
    reg_err = 8'h00; err_clear = 1'b0;
    en2 = 1'b0; h2_valid = 1'b0; h2_addr = 3'd0; h2_data = 8'h00; err2 = 6'd0; clr2 = 1'b0;
    test_reset();
    test_host_write();
    test_back_to_back();
    test_addr_err();
    test_sweep_clean();
    test_refresh();
    test_collision();
    test_saturation();
    test_reset_mid();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
